// File: rtl/mem_bus_arbiter.sv
// Two-requester memory bus arbiter (I-cache / D-cache).
// Grant is combinational with D-cache priority. An anti-starvation counter
// flips that priority once the I-cache has been denied STARVE_LIMIT cycles in a row.
// A tag owner table routes returning load data back to whichever cache issued it.
// Command encoding: 2'd0 = BUS_NONE, 2'd1 = BUS_LOAD, 2'd2 = BUS_STORE.
module mem_bus_arbiter #(
   parameter int XLEN         = 32,
   parameter int STARVE_LIMIT = 4,
   parameter int NUM_TAGS     = 15
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] icache2arb_addr,
   input  logic [1:0]      icache2arb_command,
   input  logic [XLEN-1:0] dcache2arb_addr,
   input  logic [XLEN-1:0] dcache2arb_data,
   input  logic [1:0]      dcache2arb_command,
   output logic [XLEN-1:0] arb2mem_addr,
   output logic [XLEN-1:0] arb2mem_data,
   output logic [1:0]      arb2mem_command,
   input  logic [3:0]      mem2arb_response,
   input  logic [XLEN-1:0] mem2arb_data,
   input  logic [3:0]      mem2arb_tag,
   output logic [3:0]      arb2icache_response,
   output logic [3:0]      arb2dcache_response,
   output logic [XLEN-1:0] arb2icache_data,
   output logic [3:0]      arb2icache_tag,
   output logic [XLEN-1:0] arb2dcache_data,
   output logic [3:0]      arb2dcache_tag,
   output logic            orphan_err
);

   localparam logic [1:0] BUS_NONE = 2'd0;
   localparam logic [1:0] BUS_LOAD = 2'd1;

   logic                ireq, dreq, igrant, dgrant;
   logic [2:0]          starve_q, starve_d;
   // Index 0 is never used: tag 0 means "no tag".
   logic [NUM_TAGS:0]   valid_q, valid_d, owner_q, owner_d;
   logic                orphan_q, orphan_d;
   logic                ret_hit, alloc;

   // Pick the winner: D-cache by default, I-cache once it has starved long enough.
   always_comb begin
      ireq   = (icache2arb_command != BUS_NONE);
      dreq   = (dcache2arb_command != BUS_NONE);
      igrant = ireq && (!dreq || (int'(starve_q) >= STARVE_LIMIT));
      dgrant = dreq && !igrant;
   end

   // Forward the granted request and hand the acceptance tag only to its issuer.
   always_comb begin
      arb2mem_command     = BUS_NONE;
      arb2mem_addr        = '0;
      arb2mem_data        = '0;
      arb2icache_response = 4'd0;
      arb2dcache_response = 4'd0;
      if (igrant) begin
         arb2mem_command     = icache2arb_command;
         arb2mem_addr        = icache2arb_addr;
         arb2icache_response = mem2arb_response;
      end else if (dgrant) begin
         arb2mem_command     = dcache2arb_command;
         arb2mem_addr        = dcache2arb_addr;
         arb2mem_data        = dcache2arb_data;
         arb2dcache_response = mem2arb_response;
      end
   end

   // Route returning load data to the recorded owner; unknown tags go nowhere.
   always_comb begin
      ret_hit         = (mem2arb_tag != 4'd0) && (int'(mem2arb_tag) <= NUM_TAGS)
                        && valid_q[mem2arb_tag];
      arb2icache_tag  = 4'd0;
      arb2icache_data = '0;
      arb2dcache_tag  = 4'd0;
      arb2dcache_data = '0;
      if (ret_hit) begin
         if (owner_q[mem2arb_tag]) begin
            arb2dcache_tag  = mem2arb_tag;
            arb2dcache_data = mem2arb_data;
         end else begin
            arb2icache_tag  = mem2arb_tag;
            arb2icache_data = mem2arb_data;
         end
      end
   end

   // Next state: starvation count, table free-on-return then allocate-on-accept.
   // Allocation is applied last so a same-cycle free/realloc of one tag keeps it valid.
   always_comb begin
      if (ireq && !(igrant && (mem2arb_response != 4'd0)))
         starve_d = (starve_q == 3'd7) ? 3'd7 : starve_q + 3'd1;
      else
         starve_d = 3'd0;
      valid_d  = valid_q;
      owner_d  = owner_q;
      orphan_d = orphan_q;
      if (mem2arb_tag != 4'd0) begin
         if (ret_hit) valid_d[mem2arb_tag] = 1'b0;
         else         orphan_d             = 1'b1;
      end
      alloc = (arb2mem_command == BUS_LOAD) && (mem2arb_response != 4'd0)
              && (int'(mem2arb_response) <= NUM_TAGS);
      if (alloc) begin
         valid_d[mem2arb_response] = 1'b1;
         owner_d[mem2arb_response] = dgrant;
      end
   end

   // State registers; reset empties the table and clears the sticky error.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         starve_q <= 3'd0;
         valid_q  <= '0;
         owner_q  <= '0;
         orphan_q <= 1'b0;
      end else begin
         starve_q <= starve_d;
         valid_q  <= valid_d;
         owner_q  <= owner_d;
         orphan_q <= orphan_d;
      end
   end

   assign orphan_err = orphan_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus a random
// run against a behavioural model (denial counter, per-tag owner arrays).
module tb_mem_bus_arbiter;

   localparam logic [1:0] NONE = 2'd0, LOAD = 2'd1, STORE = 2'd2;
   localparam int LIMIT = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] ic_addr = '0, dc_addr = '0, dc_data = '0, mem_data = '0;
   logic [1:0]  ic_cmd = NONE, dc_cmd = NONE;
   logic [3:0]  mem_resp = '0, mem_tag = '0;
   logic [31:0] m_addr, m_data, i_data, d_data;
   logic [1:0]  m_cmd;
   logic [3:0]  i_resp, d_resp, i_tag, d_tag;
   logic        orphan;

   int total = 0, bad = 0;

   // behavioural model state
   int   starve = 0;
   bit   mvalid[16];
   bit   mowner[16];
   bit   morphan = 0;
   bit   m_igr, m_dgr;
   logic [31:0] e_addr, e_data, e_idata, e_ddata;
   logic [1:0]  e_cmd;
   logic [3:0]  e_iresp, e_dresp, e_itag, e_dtag;

   always #5 clk = ~clk;

   mem_bus_arbiter #(.XLEN(32), .STARVE_LIMIT(LIMIT), .NUM_TAGS(15)) dut (
      .clk(clk), .rst(rst),
      .icache2arb_addr(ic_addr), .icache2arb_command(ic_cmd),
      .dcache2arb_addr(dc_addr), .dcache2arb_data(dc_data), .dcache2arb_command(dc_cmd),
      .arb2mem_addr(m_addr), .arb2mem_data(m_data), .arb2mem_command(m_cmd),
      .mem2arb_response(mem_resp), .mem2arb_data(mem_data), .mem2arb_tag(mem_tag),
      .arb2icache_response(i_resp), .arb2dcache_response(d_resp),
      .arb2icache_data(i_data), .arb2icache_tag(i_tag),
      .arb2dcache_data(d_data), .arb2dcache_tag(d_tag),
      .orphan_err(orphan));

   task automatic model_clear();
      starve = 0; morphan = 0;
      for (int t = 0; t < 16; t++) begin mvalid[t] = 0; mowner[t] = 0; end
   endtask

   // Drive one cycle of inputs (called just after a rising edge), compute the
   // expected combinational outputs, then wait for the falling edge to sample.
   task automatic apply(input logic [1:0] ic, input logic [31:0] ia,
                        input logic [1:0] dc, input logic [31:0] da, input logic [31:0] dd,
                        input logic [3:0] resp, input logic [3:0] tag, input logic [31:0] md);
      bit hit;
      ic_cmd = ic; ic_addr = ia; dc_cmd = dc; dc_addr = da; dc_data = dd;
      mem_resp = resp; mem_tag = tag; mem_data = md;
      m_igr   = (ic != NONE) && ((dc == NONE) || starve >= LIMIT);
      m_dgr   = (dc != NONE) && !m_igr;
      e_cmd   = m_igr ? ic : (m_dgr ? dc : NONE);
      e_addr  = m_igr ? ia : (m_dgr ? da : 32'd0);
      e_data  = m_dgr ? dd : 32'd0;
      e_iresp = m_igr ? resp : 4'd0;
      e_dresp = m_dgr ? resp : 4'd0;
      hit     = (tag != 0) && mvalid[tag];
      e_itag  = (hit && !mowner[tag]) ? tag : 4'd0;
      e_idata = (hit && !mowner[tag]) ? md : 32'd0;
      e_dtag  = (hit && mowner[tag]) ? tag : 4'd0;
      e_ddata = (hit && mowner[tag]) ? md : 32'd0;
      @(negedge clk);
   endtask

   // Advance the model by the rules of the current cycle, then cross the edge.
   task automatic tick();
      if ((ic_cmd != NONE) && !(m_igr && mem_resp != 0)) starve = (starve < 7) ? starve + 1 : 7;
      else starve = 0;
      if (mem_tag != 0) begin
         if (mvalid[mem_tag]) mvalid[mem_tag] = 0;
         else morphan = 1;
      end
      if (e_cmd == LOAD && mem_resp != 0) begin
         mvalid[mem_resp] = 1; mowner[mem_resp] = m_dgr;
      end
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      ic_cmd = NONE; dc_cmd = NONE; mem_resp = 0; mem_tag = 0;
      model_clear();
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
   endtask

   task automatic test_reset();
      mem_tag = 4'd5; mem_data = 32'h77; dc_cmd = NONE; ic_cmd = NONE;
      #3;
      total++; if (orphan !== 1'b0) begin bad++; $display("FAIL reset_orphan got=%0b want=0", orphan); end
      total++; if (m_cmd !== NONE || m_addr !== 0 || m_data !== 0) begin
         bad++; $display("FAIL reset_bus got cmd=%0d addr=%h data=%h want 0", m_cmd, m_addr, m_data); end
      total++; if (i_tag !== 0 || d_tag !== 0 || i_data !== 0 || d_data !== 0) begin
         bad++; $display("FAIL reset_route got itag=%0d dtag=%0d want 0", i_tag, d_tag); end
      @(posedge clk); #1;
      total++; if (orphan !== 1'b0) begin bad++; $display("FAIL reset_hold got=%0b want=0", orphan); end
      do_reset();
   endtask

   task automatic test_basic_load();
      do_reset();
      apply(NONE, 0, LOAD, 32'h100, 0, 4'd3, 0, 0);
      total++; if (m_addr !== 32'h100 || m_cmd !== LOAD) begin
         bad++; $display("FAIL basic_grant got addr=%h cmd=%0d want 100/1", m_addr, m_cmd); end
      total++; if (d_resp !== 4'd3 || i_resp !== 4'd0) begin
         bad++; $display("FAIL basic_resp got d=%0d i=%0d want 3/0", d_resp, i_resp); end
      tick();
      apply(NONE, 0, NONE, 0, 0, 0, 4'd3, 32'hDEAD);
      total++; if (d_tag !== 4'd3 || d_data !== 32'hDEAD || i_tag !== 4'd0) begin
         bad++; $display("FAIL basic_return got dtag=%0d ddata=%h itag=%0d want 3/dead/0", d_tag, d_data, i_tag); end
      tick();
      apply(NONE, 0, NONE, 0, 0, 0, 0, 0);
      total++; if (orphan !== 1'b0) begin bad++; $display("FAIL basic_orphan got=%0b want=0", orphan); end
      tick();
   endtask

   task automatic test_starvation();
      logic [3:0] r;
      bit want_i;
      do_reset();
      for (int c = 0; c < 10; c++) begin
         r = 4'((c % 15) + 1);
         want_i = (c % 5 == 4);
         apply(LOAD, 32'h200 + c, LOAD, 32'h300 + c, 32'h5, r, 0, 0);
         total++;
         if (i_resp !== (want_i ? r : 4'd0) || d_resp !== (want_i ? 4'd0 : r) ||
             m_addr !== (want_i ? 32'h200 + c : 32'h300 + c)) begin
            bad++; $display("FAIL starve_c%0d got i=%0d d=%0d addr=%h want_icache=%0b", c, i_resp, d_resp, m_addr, want_i);
         end
         tick();
      end
   endtask

   task automatic test_store_orphan();
      do_reset();
      apply(LOAD, 32'h40, NONE, 0, 0, 4'd5, 0, 0);
      total++; if (i_resp !== 4'd5) begin bad++; $display("FAIL so_iload got=%0d want=5", i_resp); end
      tick();
      apply(NONE, 0, STORE, 32'h80, 32'h55, 4'd6, 0, 0);
      total++; if (d_resp !== 4'd6 || m_cmd !== STORE || m_data !== 32'h55) begin
         bad++; $display("FAIL so_store got resp=%0d cmd=%0d data=%h want 6/2/55", d_resp, m_cmd, m_data); end
      tick();
      apply(NONE, 0, NONE, 0, 0, 0, 4'd5, 32'h1234);
      total++; if (i_tag !== 4'd5 || i_data !== 32'h1234 || d_tag !== 0) begin
         bad++; $display("FAIL so_ret5 got itag=%0d idata=%h dtag=%0d want 5/1234/0", i_tag, i_data, d_tag); end
      tick();
      apply(NONE, 0, NONE, 0, 0, 0, 4'd6, 32'h9999);
      total++; if (i_tag !== 0 || d_tag !== 0 || d_data !== 0) begin
         bad++; $display("FAIL so_ret6 got itag=%0d dtag=%0d want 0/0", i_tag, d_tag); end
      total++; if (orphan !== 1'b0) begin bad++; $display("FAIL so_pre got=%0b want=0", orphan); end
      tick();
      apply(NONE, 0, NONE, 0, 0, 0, 0, 0);
      total++; if (orphan !== 1'b1) begin bad++; $display("FAIL so_orphan got=%0b want=1", orphan); end
      tick();
   endtask

   task automatic test_same_cycle();
      do_reset();
      apply(LOAD, 32'h10, NONE, 0, 0, 4'd2, 0, 0);
      tick();
      apply(NONE, 0, LOAD, 32'h500, 0, 4'd2, 4'd2, 32'hAAAA);
      total++; if (i_tag !== 4'd2 || i_data !== 32'hAAAA || d_tag !== 0) begin
         bad++; $display("FAIL sc_ret got itag=%0d idata=%h dtag=%0d want 2/aaaa/0", i_tag, i_data, d_tag); end
      total++; if (d_resp !== 4'd2 || m_addr !== 32'h500) begin
         bad++; $display("FAIL sc_grant got dresp=%0d addr=%h want 2/500", d_resp, m_addr); end
      tick();
      apply(NONE, 0, NONE, 0, 0, 0, 4'd2, 32'hBBBB);
      total++; if (d_tag !== 4'd2 || d_data !== 32'hBBBB || i_tag !== 0) begin
         bad++; $display("FAIL sc_realloc got dtag=%0d ddata=%h itag=%0d want 2/bbbb/0", d_tag, d_data, i_tag); end
      tick();
      apply(NONE, 0, NONE, 0, 0, 0, 0, 0);
      total++; if (orphan !== 1'b0) begin bad++; $display("FAIL sc_orphan got=%0b want=0", orphan); end
      tick();
   endtask

   task automatic test_retry();
      do_reset();
      for (int c = 0; c < 3; c++) begin
         apply(LOAD, 32'h700, NONE, 0, 0, 4'd0, 0, 0);
         total++; if (i_resp !== 0 || m_cmd !== LOAD || m_addr !== 32'h700) begin
            bad++; $display("FAIL retry_c%0d got resp=%0d cmd=%0d addr=%h want 0/1/700", c, i_resp, m_cmd, m_addr); end
         tick();
      end
      // three denials so far: D-cache still wins once, then the I-cache
      apply(LOAD, 32'h700, LOAD, 32'h800, 0, 4'd9, 0, 0);
      total++; if (d_resp !== 4'd9 || i_resp !== 0) begin
         bad++; $display("FAIL retry_d got d=%0d i=%0d want 9/0", d_resp, i_resp); end
      tick();
      apply(LOAD, 32'h700, LOAD, 32'h800, 0, 4'd10, 0, 0);
      total++; if (i_resp !== 4'd10 || d_resp !== 0) begin
         bad++; $display("FAIL retry_i got i=%0d d=%0d want 10/0", i_resp, d_resp); end
      tick();
      // a refused request allocated nothing: tag 1 was never accepted
      apply(NONE, 0, NONE, 0, 0, 0, 4'd1, 32'h1);
      total++; if (i_tag !== 0 || d_tag !== 0) begin
         bad++; $display("FAIL retry_noalloc got itag=%0d dtag=%0d want 0/0", i_tag, d_tag); end
      tick();
   endtask

   task automatic test_reset_outstanding();
      // orphan is set from the previous scenario; reset must clear it without a clock edge
      rst = 1'b0; #2;
      total++; if (orphan !== 1'b0) begin bad++; $display("FAIL ro_async got=%0b want=0", orphan); end
      do_reset();
      apply(LOAD, 32'h20, NONE, 0, 0, 4'd1, 0, 0);
      tick();
      apply(NONE, 0, LOAD, 32'h30, 0, 4'd4, 0, 0);
      tick();
      do_reset();
      apply(NONE, 0, NONE, 0, 0, 0, 4'd4, 32'hCAFE);
      total++; if (i_tag !== 0 || d_tag !== 0 || orphan !== 1'b0) begin
         bad++; $display("FAIL ro_ret got itag=%0d dtag=%0d orphan=%0b want 0/0/0", i_tag, d_tag, orphan); end
      tick();
      apply(NONE, 0, NONE, 0, 0, 0, 0, 0);
      total++; if (orphan !== 1'b1) begin bad++; $display("FAIL ro_orphan got=%0b want=1", orphan); end
      tick();
   endtask

   task automatic test_random();
      logic [1:0] ic, dc;
      logic [3:0] r, t;
      do_reset();
      for (int c = 0; c < 400; c++) begin
         ic = ($urandom_range(0, 9) < 7) ? LOAD : NONE;
         dc = 2'($urandom_range(0, 2));
         r  = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
         t  = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
         apply(ic, $urandom, dc, $urandom, $urandom, r, t, $urandom);
         total++;
         if (m_cmd !== e_cmd || m_addr !== e_addr || m_data !== e_data) begin
            bad++; $display("FAIL rnd_bus c=%0d got %0d/%h/%h want %0d/%h/%h", c, m_cmd, m_addr, m_data, e_cmd, e_addr, e_data);
         end
         total++;
         if (i_resp !== e_iresp || d_resp !== e_dresp) begin
            bad++; $display("FAIL rnd_resp c=%0d got i=%0d d=%0d want i=%0d d=%0d", c, i_resp, d_resp, e_iresp, e_dresp);
         end
         total++;
         if (i_tag !== e_itag || i_data !== e_idata || d_tag !== e_dtag || d_data !== e_ddata) begin
            bad++; $display("FAIL rnd_ret c=%0d got it=%0d dt=%0d want it=%0d dt=%0d", c, i_tag, d_tag, e_itag, e_dtag);
         end
         total++;
         if (orphan !== morphan) begin
            bad++; $display("FAIL rnd_orphan c=%0d got=%0b want=%0b", c, orphan, morphan);
         end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_basic_load();
      test_starvation();
      test_same_cycle();
      test_retry();
      test_store_orphan();
      test_reset_outstanding();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
